// File: rtl/lpif_online_pkg.sv
// lpif_online_pkg
// Shared definitions for the LPIF online controller:
//   - lpif_state_e : 3-bit FSM state encoding (also exported on debug_status)
//   - DBG_*        : bit offsets/widths of the debug_status fields
//   - sat_inc16    : saturating increment used by the link-drop counter
package lpif_online_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PHY = 3'd1,
        ST_TX_ON    = 3'd2,
        ST_LINK_UP  = 3'd3,
        ST_BACKOFF  = 3'd4,
        ST_FAIL     = 3'd5
    } lpif_state_e;

    // debug_status = {8'h0, retry_cnt[3:0], 1'b0, state[2:0], drop_cnt[15:0]}
    localparam int DBG_DROP_LSB  = 0;
    localparam int DBG_DROP_W    = 16;
    localparam int DBG_STATE_LSB = 16;
    localparam int DBG_STATE_W   = 3;
    localparam int DBG_RETRY_LSB = 20;
    localparam int DBG_RETRY_W   = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lpif_online_timer.sv
// lpif_online_timer
// Down-counter shared by the TX_ON rx-lock window and the BACKOFF wait.
// Ports:
//   clk_wr, rst_wr_n : clock, async active-low reset
//   load, load_val   : load a new count (load wins over dec)
//   dec              : decrement by one; holds at zero
//   zero             : count is zero
module lpif_online_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk_wr,
    input  logic               rst_wr_n,
    input  logic               load,
    input  logic               dec,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] count_reg;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - TIMER_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/lpif_online_ctrl.sv
// lpif_online_ctrl
// Link bring-up controller: waits for the PHY, turns tx on, waits a bounded
// time for far-end lock, retries with backoff and gives up after a retry
// limit. All outputs are registered decodes of the FSM state.
// Ports:
//   clk_wr, rst_wr_n   : clock, async active-low reset
//   link_enable        : software request; low tears the link down
//   phy_ready          : PHY aligned
//   rx_align_done      : far-end lock seen on rx
//   cfg_rx_timeout     : TX_ON window length (cycles, value+1 TX_ON cycles)
//   cfg_backoff        : BACKOFF length (value+1 cycles)
//   cfg_retry_limit    : failed attempts tolerated before FAIL
//   tx_online/rx_online: online controls to the slave top
//   link_up/link_error : LINK_UP / FAIL indication
//   debug_status       : {8'h0, retry_cnt, 1'b0, state, drop_cnt}
module lpif_online_ctrl
    import lpif_online_pkg::*;
#(
    parameter int TIMER_W = 16,
    parameter int RETRY_W = 4
) (
    input  logic               clk_wr,
    input  logic               rst_wr_n,
    input  logic               link_enable,
    input  logic               phy_ready,
    input  logic               rx_align_done,
    input  logic [TIMER_W-1:0] cfg_rx_timeout,
    input  logic [TIMER_W-1:0] cfg_backoff,
    input  logic [RETRY_W-1:0] cfg_retry_limit,
    output logic               tx_online,
    output logic               rx_online,
    output logic               link_up,
    output logic               link_error,
    output logic [31:0]        debug_status
);

    lpif_state_e        state_reg, state_next;
    logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;
    logic [15:0]        drop_cnt_reg, drop_cnt_next;
    logic               tx_online_reg, rx_online_reg, link_up_reg, link_error_reg;

    logic               tmr_load, tmr_dec, tmr_zero, fail_attempt;
    logic [TIMER_W-1:0] tmr_val;
    logic [DBG_RETRY_W-1:0] retry_dbg;

    lpif_online_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk_wr   (clk_wr),
        .rst_wr_n (rst_wr_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_next     = state_reg;
        retry_cnt_next = retry_cnt_reg;
        drop_cnt_next  = drop_cnt_reg;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        tmr_val        = cfg_rx_timeout;
        fail_attempt   = 1'b0;

        if (!link_enable) begin
            // Teardown overrides every other transition, including drop counting.
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next     = ST_WAIT_PHY;
                    retry_cnt_next = '0;
                end
                ST_WAIT_PHY: begin
                    if (phy_ready) begin
                        state_next = ST_TX_ON;
                        tmr_load   = 1'b1;
                        tmr_val    = cfg_rx_timeout;
                    end
                end
                ST_TX_ON: begin
                    if (rx_align_done) begin
                        state_next     = ST_LINK_UP;
                        retry_cnt_next = '0;
                    end else if (!phy_ready) begin
                        state_next = ST_WAIT_PHY;
                    end else if (tmr_zero) begin
                        fail_attempt = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (!phy_ready || !rx_align_done) begin
                        fail_attempt  = 1'b1;
                        drop_cnt_next = sat_inc16(drop_cnt_reg);
                    end
                end
                ST_BACKOFF: begin
                    if (tmr_zero) begin
                        state_next = ST_WAIT_PHY;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_FAIL: state_next = ST_FAIL;
                default: state_next = ST_IDLE;
            endcase

            // '>=' keeps retry_cnt bounded even if the limit is lowered mid-run.
            if (fail_attempt) begin
                if (retry_cnt_reg >= cfg_retry_limit) begin
                    state_next = ST_FAIL;
                end else begin
                    state_next     = ST_BACKOFF;
                    retry_cnt_next = retry_cnt_reg + RETRY_W'(1);
                    tmr_load       = 1'b1;
                    tmr_val        = cfg_backoff;
                end
            end
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as state_reg and never see an input combinationally.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_reg      <= ST_IDLE;
            retry_cnt_reg  <= '0;
            drop_cnt_reg   <= '0;
            tx_online_reg  <= 1'b0;
            rx_online_reg  <= 1'b0;
            link_up_reg    <= 1'b0;
            link_error_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            retry_cnt_reg  <= retry_cnt_next;
            drop_cnt_reg   <= drop_cnt_next;
            tx_online_reg  <= (state_next == ST_TX_ON) || (state_next == ST_LINK_UP);
            rx_online_reg  <= (state_next == ST_LINK_UP);
            link_up_reg    <= (state_next == ST_LINK_UP);
            link_error_reg <= (state_next == ST_FAIL);
        end
    end

    generate
        if (RETRY_W >= DBG_RETRY_W) begin : g_retry_trunc
            assign retry_dbg = retry_cnt_reg[DBG_RETRY_W-1:0];
        end else begin : g_retry_ext
            assign retry_dbg = {{(DBG_RETRY_W-RETRY_W){1'b0}}, retry_cnt_reg};
        end
    endgenerate

    assign tx_online    = tx_online_reg;
    assign rx_online    = rx_online_reg;
    assign link_up      = link_up_reg;
    assign link_error   = link_error_reg;
    assign debug_status = {8'h0, retry_dbg, 1'b0, state_reg, drop_cnt_reg};

endmodule

// File: doc/lpif_online_ctrl.md
LPIF_ONLINE_CTRL -- requirements
Module: lpif_online_ctrl

Interface
REQ-001 Parameter TIMER_W, default 16, width of the timeout and backoff timer and its config ports.
REQ-002 Parameter RETRY_W, default 4, width of the retry counter and the retry limit.
REQ-003 clk_wr  input  1  single clock; all logic is on its rising edge.
REQ-004 rst_wr_n  input  1  reset, asynchronous assert, active-low.
REQ-005 link_enable  input  1  software request to bring the link up; low forces teardown.
REQ-006 phy_ready  input  1  PHY channel aligned and usable.
REQ-007 rx_align_done  input  1  far-end marker/strobe lock detected on rx.
REQ-008 cfg_rx_timeout  input  TIMER_W  cycles allowed in TX_ON for rx_align_done to rise.
REQ-009 cfg_backoff  input  TIMER_W  cycles that tx_online stays low before a retry.
REQ-010 cfg_retry_limit  input  RETRY_W  failed attempts tolerated before FAIL.
REQ-011 tx_online  output  1  drives the tx_online port of the slave top.
REQ-012 rx_online  output  1  drives the rx_online port of the slave top.
REQ-013 link_up  output  1  high only in LINK_UP.
REQ-014 link_error  output  1  high only in FAIL.
REQ-015 debug_status  output  32  {8'h0, retry_cnt, 1'b0, state[2:0], drop_cnt[15:0]}.

Function
REQ-016 The FSM SHALL have these states: IDLE=0, WAIT_PHY=1, TX_ON=2, LINK_UP=3, BACKOFF=4, FAIL=5.
REQ-017 All outputs SHALL be Moore decodes of the registered state, valid in the cycle after the transition edge, with no combinational path from any input.
REQ-018 tx_online SHALL be 1 in TX_ON and LINK_UP; rx_online SHALL be 1 in LINK_UP only.
REQ-019 link_enable low SHALL move any state to IDLE on the next edge, with the highest priority of all transitions.
REQ-020 IDLE: when link_enable=1, go to WAIT_PHY and clear retry_cnt.
REQ-021 WAIT_PHY: when phy_ready=1, go to TX_ON and load timer=cfg_rx_timeout.
REQ-022 TX_ON: rx_align_done=1 goes to LINK_UP; otherwise phy_ready=0 goes to WAIT_PHY with no retry increment; otherwise timer==0 is a failed attempt; otherwise timer decrements.
REQ-023 Priority in TX_ON SHALL be: rx_align_done over phy_ready loss over timeout.
REQ-024 cfg_rx_timeout=0 SHALL time out on the first TX_ON cycle unless rx_align_done is high in that same cycle.
REQ-025 Failed attempt: if retry_cnt==cfg_retry_limit, go to FAIL; else increment retry_cnt, load timer=cfg_backoff, go to BACKOFF.
REQ-026 BACKOFF: timer decrements each cycle; at timer==0 go to WAIT_PHY. cfg_backoff=0 gives exactly one BACKOFF cycle.
REQ-027 Entering LINK_UP SHALL clear retry_cnt.
REQ-028 LINK_UP: phy_ready=0 or rx_align_done=0 SHALL be a failed attempt (REQ-025) and SHALL increment drop_cnt.
REQ-029 drop_cnt SHALL be 16 bits, saturate at 16'hFFFF, and is cleared only by reset.
REQ-030 FAIL SHALL be sticky until link_enable=0.
REQ-031 retry_cnt SHALL never exceed cfg_retry_limit.
REQ-032 Config inputs SHALL be sampled only when the timer is loaded or compared; changes mid-count do not affect the running timer.

Reset
REQ-033 Asserting rst_wr_n=0 SHALL immediately set state=IDLE, timer=0, retry_cnt=0, drop_cnt=0, and all outputs to 0.
REQ-034 Reset asserted mid-operation (including LINK_UP) SHALL drop tx_online and rx_online asynchronously.
REQ-035 After release, the first transition SHALL occur no earlier than the first rising edge with link_enable=1.

Structure
REQ-036 Package lpif_online_pkg SHALL hold the state enum typedef (3 bits) and the debug_status field offsets.
REQ-037 The timer SHALL be a sub-module, lpif_online_timer (load, decrement, zero flag), instantiated once and shared by TX_ON and BACKOFF.
REQ-038 Estimated size: 150-250 lines of RTL.

Verification
REQ-039 Bring-up: link_enable=1, phy_ready=1, rx_align_done rises 5 cycles after tx_online, cfg_rx_timeout=100 -> tx_online, then rx_online and link_up; retry_cnt=0.
REQ-040 Timeout/retry: cfg_rx_timeout=10, cfg_backoff=4, cfg_retry_limit=2, rx_align_done=0 -> three TX_ON windows of 11 cycles each, 5-cycle BACKOFF gaps, then FAIL with link_error=1 and debug_status[23:20]=2.
REQ-041 Link drop: phy_ready pulled low for 1 cycle in LINK_UP -> rx_online and tx_online fall, drop_cnt=1, then retry reaches LINK_UP again.
REQ-042 Simultaneous events: rx_align_done rises on the same cycle the timer hits 0 -> LINK_UP, no retry; link_enable=0 with phy_ready loss -> IDLE.
REQ-043 Reset mid-LINK_UP: rst_wr_n=0 -> outputs 0 with no clock edge; release with link_enable=1 -> WAIT_PHY on the first edge.
REQ-044 Edge config: cfg_rx_timeout=0, cfg_backoff=0, cfg_retry_limit=0 -> one TX_ON cycle, then FAIL.
